// File: rtl/tcore_branch_resolve_pkg.sv
// Shared types for the execute-side branch prediction resolver.
//   predict_info_t  : what fetch predicted (direction + taken target)
//   resolve_entry_t : one queued prediction, with what is needed to rebuild the fall-through PC
//   resolve_state_e : resolver FSM states
package tcore_branch_resolve_pkg;

    typedef struct packed {
        logic        taken;
        logic [31:0] pc;
    } predict_info_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic [31:0] instr_pc;
        logic        is_c;
    } resolve_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        REDIR = 1'b1
    } resolve_state_e;

    // Next sequential PC after a control-flow instruction (32-bit wrap).
    function automatic logic [31:0] fall_through(input logic [31:0] pc, input logic is_c);
        return pc + (is_c ? 32'd2 : 32'd4);
    endfunction

endpackage

// File: rtl/tcore_pred_fifo.sv
// Synchronous FIFO holding outstanding predictions.
//   clk, rst_n  : clock, async active-low reset
//   clear       : empties the FIFO next cycle; wins over a same-cycle push/pop
//   push, din   : write when not full
//   pop, dout   : dout is the oldest entry; pop advances when not empty
//   full, empty : occupancy flags
module tcore_pred_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0] wr_ptr, rd_ptr;
    T            mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !clear) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/tcore_branch_resolve.sv
// Resolves fetch-stage static predictions against execute outcomes, in order.
//   pred_*     : fetch pushes a prediction per control-flow instruction
//   res_*      : execute resolves the oldest queued instruction
//   flush_i    : clears queue and any pending redirect
//   redirect_* : redirect request to fetch, held until redirect_ready_i
//   mispredict_o, cnt_* : one-cycle mispredict pulse and saturating counters
module tcore_branch_resolve
    import tcore_branch_resolve_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pred_valid_i,
    output logic             pred_ready_o,
    input  predict_info_t    pred_i,
    input  logic [31:0]      pred_instr_pc_i,
    input  logic             pred_is_c_i,
    input  logic             res_valid_i,
    output logic             res_ready_o,
    input  logic             res_taken_i,
    input  logic [31:0]      res_target_i,
    input  logic             flush_i,
    output logic             redirect_o,
    output logic [31:0]      redirect_pc_o,
    input  logic             redirect_ready_i,
    output logic             mispredict_o,
    output logic [CNT_W-1:0] cnt_branch_o,
    output logic [CNT_W-1:0] cnt_mispred_o
);
    resolve_state_e state_q, state_d;
    resolve_entry_t push_entry, head;
    logic           full, empty;
    logic           push, pop, resolve, mispred, fifo_clear;
    logic [31:0]    correct_pc;

    assign pred_ready_o = !full  && (state_q == RUN);
    assign res_ready_o  = !empty && (state_q == RUN);
    assign push         = pred_valid_i && pred_ready_o;
    assign pop          = res_valid_i && res_ready_o;
    // A flush cancels any same-cycle resolve entirely.
    assign resolve      = pop && !flush_i;

    assign push_entry = '{taken: pred_i.taken, target: pred_i.pc,
                          instr_pc: pred_instr_pc_i, is_c: pred_is_c_i};

    assign mispred    = (res_taken_i != head.taken) ||
                        (res_taken_i && head.taken && (res_target_i != head.target));
    assign correct_pc = res_taken_i ? res_target_i : fall_through(head.instr_pc, head.is_c);

    // Everything younger than a mispredicted branch is wrong-path.
    assign fifo_clear = flush_i || (resolve && mispred);

    tcore_pred_fifo #(.DEPTH(DEPTH), .T(resolve_entry_t)) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clear (fifo_clear),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     if (resolve && mispred) state_d = REDIR;
                REDIR:   if (redirect_ready_i)   state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= RUN;
            redirect_pc_o <= '0;
            mispredict_o  <= 1'b0;
            cnt_branch_o  <= '0;
            cnt_mispred_o <= '0;
        end else begin
            state_q      <= state_d;
            mispredict_o <= resolve && mispred;
            if (resolve && mispred) redirect_pc_o <= correct_pc;
            if (resolve && (cnt_branch_o != {CNT_W{1'b1}}))
                cnt_branch_o <= cnt_branch_o + 1'b1;
            if (resolve && mispred && (cnt_mispred_o != {CNT_W{1'b1}}))
                cnt_mispred_o <= cnt_mispred_o + 1'b1;
        end
    end

    assign redirect_o = (state_q == REDIR);

    // Execute must never resolve with nothing outstanding.
    a_resolve_nonempty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(res_valid_i && empty && (state_q == RUN) && !flush_i));

endmodule
